// File: rtl/fifo_wr_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_stream
// Brief    : Async-FIFO write-side producer: valid/ready stream into a 2-entry
//            skid buffer, drained through winc/wdata while wfull is low.
//            Optional FIFO_WR_PKT_EN adds packet tracking (pkt_cnt/pkt_done).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  winc,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wfull,
    output logic [CNT_WIDTH-1:0]  wr_words,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic                  pkt_done
);

    logic [1:0]            r_occ;
    logic                  r_s_ready;
    logic [DATA_WIDTH-1:0] r_data [2];
    logic [CNT_WIDTH-1:0]  r_wr_words;

    logic                  w_push;
    logic                  w_pop;
    logic [1:0]            w_occ_next;
    logic [1:0]            w_fill;
    logic                  w_wr_idx;
    logic                  w_unused_last;

    assign w_push     = s_valid && r_s_ready;
    assign w_pop      = (r_occ != 2'd0) && !wfull;
    assign w_occ_next = r_occ + 2'(w_push) - 2'(w_pop);

    // Slot for the incoming word after this cycle's pop has shifted entry 1
    // into the head; a push only happens with occ <= 1, so fill is 0 or 1.
    assign w_fill   = r_occ - 2'(w_pop);
    assign w_wr_idx = w_fill[0];

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            r_occ      <= 2'd0;
            r_s_ready  <= 1'b0;
            r_wr_words <= '0;
        end else begin
            r_occ     <= w_occ_next;
            r_s_ready <= (w_occ_next != 2'd2);
            if (w_pop && (r_wr_words != {CNT_WIDTH{1'b1}})) begin
                r_wr_words <= r_wr_words + CNT_WIDTH'(1);
            end
        end
    end

    // Pop shifts entry 1 into the head; a same-cycle push into slot 0 wins.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
        end else begin
            if (w_pop) begin
                r_data[0] <= r_data[1];
            end
            if (w_push) begin
                r_data[w_wr_idx] <= s_data;
            end
        end
    end

    assign s_ready  = r_s_ready;
    assign winc     = w_pop;
    assign wdata    = r_data[0];
    assign wr_words = r_wr_words;

`ifdef FIFO_WR_PKT_EN
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } pkt_state_t;

    pkt_state_t           r_state;
    pkt_state_t           w_state_next;
    logic                 r_last [2];
    logic                 r_pkt_done;
    logic                 w_pkt_done_next;
    logic [CNT_WIDTH-1:0] r_pkt_cnt;

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            r_last[0] <= 1'b0;
            r_last[1] <= 1'b0;
        end else begin
            if (w_pop) begin
                r_last[0] <= r_last[1];
            end
            if (w_push) begin
                r_last[w_wr_idx] <= s_last;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pkt_done_next = w_pop && r_last[0];
        case (r_state)
            ST_IDLE: begin
                if (w_push && !s_last) begin
                    w_state_next = ST_IN_PKT;
                end
            end
            ST_IN_PKT: begin
                // A new multi-word packet starting this cycle keeps us in-packet.
                if (w_pop && r_last[0] && !(w_push && !s_last)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            r_state    <= ST_IDLE;
            r_pkt_done <= 1'b0;
            r_pkt_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pkt_done <= w_pkt_done_next;
            if (w_pkt_done_next && (r_pkt_cnt != {CNT_WIDTH{1'b1}})) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign pkt_cnt       = r_pkt_cnt;
    assign pkt_done      = r_pkt_done;
    assign w_unused_last = 1'b0;
`else
    assign pkt_cnt       = '0;
    assign pkt_done      = 1'b0;
    assign w_unused_last = s_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_stream.sv
`default_nettype none
// Directed testbench for fifo_wr_stream; packet checks adapt to FIFO_WR_PKT_EN.
module tb_fifo_wr_stream;

`ifdef FIFO_WR_PKT_EN
    localparam bit PKT_EN = 1'b1;
`else
    localparam bit PKT_EN = 1'b0;
`endif

    logic        w_clk;
    logic        w_rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        winc;
    logic [7:0]  wdata;
    logic        wfull;
    logic [15:0] wr_words;
    logic [15:0] pkt_cnt;
    logic        pkt_done;

    logic        sat_valid;
    logic [7:0]  sat_data;
    logic        sat_last;
    logic        sat_ready;
    logic        sat_winc;
    logic [7:0]  sat_wdata;
    logic        sat_wfull;
    logic [2:0]  sat_words;
    logic [2:0]  sat_pkt_cnt;
    logic        sat_pkt_done;

    int checks = 0;
    int errors = 0;

    fifo_wr_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .w_clk(w_clk), .w_rst(w_rst),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .winc(winc), .wdata(wdata), .wfull(wfull),
        .wr_words(wr_words), .pkt_cnt(pkt_cnt), .pkt_done(pkt_done)
    );

    fifo_wr_stream #(.DATA_WIDTH(8), .CNT_WIDTH(3)) dut_sat (
        .w_clk(w_clk), .w_rst(w_rst),
        .s_valid(sat_valid), .s_data(sat_data), .s_last(sat_last), .s_ready(sat_ready),
        .winc(sat_winc), .wdata(sat_wdata), .wfull(sat_wfull),
        .wr_words(sat_words), .pkt_cnt(sat_pkt_cnt), .pkt_done(sat_pkt_done)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic test_reset();
        w_rst = 1'b0;
        step(); step(); step();
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got %b exp 0", s_ready); end
        checks++; if (winc !== 1'b0) begin errors++; $display("FAIL rst_winc got %b exp 0", winc); end
        checks++; if (wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata got %h exp 00", wdata); end
        checks++; if (wr_words !== 16'd0) begin errors++; $display("FAIL rst_wr_words got %0d exp 0", wr_words); end
        checks++; if (pkt_cnt !== 16'd0 || pkt_done !== 1'b0) begin errors++; $display("FAIL rst_pkt got %0d/%b exp 0/0", pkt_cnt, pkt_done); end
        w_rst = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rel_s_ready_early got %b exp 0", s_ready); end
        step();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rel_s_ready got %b exp 1", s_ready); end
    endtask

    task automatic test_stream();
        int sent = 0, got = 0, first_acc = -1, first_winc = -1, last_winc = -1;
        logic acc;
        wfull = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
            s_valid = (sent < 16);
            s_data  = 8'(sent + 1);
            #1;
            acc = s_valid && s_ready;
            if (winc) begin
                checks++;
                if (wdata !== 8'(got + 1)) begin errors++; $display("FAIL stream_data got %h exp %h", wdata, 8'(got + 1)); end
                if (first_winc < 0) first_winc = cyc;
                last_winc = cyc;
                got++;
            end
            step();
            if (acc) begin
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
        end
        s_valid = 1'b0;
        checks++; if (got != 16) begin errors++; $display("FAIL stream_count got %0d exp 16", got); end
        checks++; if (first_winc != first_acc + 1) begin errors++; $display("FAIL stream_latency got %0d exp %0d", first_winc, first_acc + 1); end
        checks++; if (last_winc - first_winc != 15) begin errors++; $display("FAIL stream_back_to_back got span %0d exp 15", last_winc - first_winc); end
        checks++; if (wr_words !== 16'd16) begin errors++; $display("FAIL stream_wr_words got %0d exp 16", wr_words); end
    endtask

    task automatic test_wfull_hold();
        int sent = 0, got = 0;
        logic acc;
        wfull = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h31 + sent);
            #1;
            acc = s_ready;
            checks++; if (winc !== 1'b0) begin errors++; $display("FAIL hold_winc got %b exp 0", winc); end
            step();
            if (acc) sent++;
        end
        checks++; if (sent != 2) begin errors++; $display("FAIL hold_accepted got %0d exp 2", sent); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL hold_s_ready got %b exp 0", s_ready); end
        wfull = 1'b0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            s_valid = (sent < 4);
            s_data  = 8'(8'h31 + sent);
            #1;
            acc = s_valid && s_ready;
            if (winc) begin
                checks++;
                if (wdata !== 8'(8'h31 + got)) begin errors++; $display("FAIL hold_data got %h exp %h", wdata, 8'(8'h31 + got)); end
                got++;
            end
            step();
            if (acc) sent++;
        end
        s_valid = 1'b0;
        checks++; if (got != 4) begin errors++; $display("FAIL hold_count got %0d exp 4", got); end
        checks++; if (wr_words !== 16'd20) begin errors++; $display("FAIL hold_wr_words got %0d exp 20", wr_words); end
    endtask

    task automatic test_wfull_toggle();
        int sent = 0, got = 0;
        logic acc;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            wfull   = (cyc % 2 == 1);
            s_valid = (sent < 8);
            s_data  = 8'(8'hA0 + sent);
            #1;
            acc = s_valid && s_ready;
            if (wfull) begin
                checks++; if (winc !== 1'b0) begin errors++; $display("FAIL toggle_gate got winc %b exp 0", winc); end
            end else if (winc) begin
                checks++;
                if (wdata !== 8'(8'hA0 + got)) begin errors++; $display("FAIL toggle_data got %h exp %h", wdata, 8'(8'hA0 + got)); end
                got++;
            end
            step();
            if (acc) sent++;
        end
        s_valid = 1'b0;
        wfull   = 1'b0;
        checks++; if (got != 8) begin errors++; $display("FAIL toggle_count got %0d exp 8", got); end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (winc !== 1'b0) begin errors++; $display("FAIL toggle_no_dup got %b exp 0", winc); end
            step();
        end
        checks++; if (wr_words !== 16'd28) begin errors++; $display("FAIL toggle_wr_words got %0d exp 28", wr_words); end
    endtask

    task automatic test_pkt();
        logic [7:0] pw [4] = '{8'h11, 8'h12, 8'h13, 8'h21};
        logic       pl [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int sent = 0, got = 0, pulses = 0;
        logic acc, prev_last_pop = 1'b0;
        wfull = 1'b0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            s_valid = (sent < 4);
            s_data  = (sent < 4) ? pw[sent] : 8'h00;
            s_last  = (sent < 4) ? pl[sent] : 1'b0;
            #1;
            acc = s_valid && s_ready;
            checks++; if (pkt_done !== (PKT_EN && prev_last_pop)) begin errors++; $display("FAIL pkt_done got %b exp %b", pkt_done, PKT_EN && prev_last_pop); end
            if (pkt_done === 1'b1) pulses++;
            prev_last_pop = 1'b0;
            if (winc) begin
                checks++;
                if (wdata !== pw[got]) begin errors++; $display("FAIL pkt_data got %h exp %h", wdata, pw[got]); end
                prev_last_pop = pl[got];
                got++;
            end
            step();
            if (acc) sent++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++; if (got != 4) begin errors++; $display("FAIL pkt_count got %0d exp 4", got); end
        checks++; if (pkt_done !== (PKT_EN && prev_last_pop)) begin errors++; $display("FAIL pkt_done_last got %b exp %b", pkt_done, PKT_EN && prev_last_pop); end
        if (pkt_done === 1'b1) pulses++;
        step();
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL pkt_done_clear got %b exp 0", pkt_done); end
        checks++; if (pulses != (PKT_EN ? 2 : 0)) begin errors++; $display("FAIL pkt_pulses got %0d exp %0d", pulses, PKT_EN ? 2 : 0); end
        checks++; if (pkt_cnt !== (PKT_EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL pkt_cnt got %0d exp %0d", pkt_cnt, PKT_EN ? 2 : 0); end
    endtask

    task automatic test_reset_mid();
        int sent = 0;
        logic acc;
        wfull = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h71 + sent);
            #1;
            acc = s_ready;
            step();
            if (acc) sent++;
        end
        checks++; if (sent != 2) begin errors++; $display("FAIL mid_fill got %0d exp 2", sent); end
        w_rst   = 1'b0;
        wfull   = 1'b0;
        s_valid = 1'b0;
        #1;
        checks++; if (winc !== 1'b0) begin errors++; $display("FAIL mid_rst_winc got %b exp 0", winc); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_s_ready got %b exp 0", s_ready); end
        checks++; if (wr_words !== 16'd0) begin errors++; $display("FAIL mid_rst_wr_words got %0d exp 0", wr_words); end
        checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_pkt_cnt got %0d exp 0", pkt_cnt); end
        step(); step();
        w_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (winc !== 1'b0) begin errors++; $display("FAIL mid_stale_winc got %b exp 0", winc); end
            step();
        end
        checks++; if (wr_words !== 16'd0) begin errors++; $display("FAIL mid_after_wr_words got %0d exp 0", wr_words); end
    endtask

    task automatic test_saturate();
        int cnt = 0;
        logic w;
        for (int cyc = 0; cyc < 30 && cnt < 9; cyc++) begin
            sat_valid = 1'b1;
            sat_data  = 8'(cnt);
            #1;
            w = sat_winc;
            step();
            if (w) begin
                cnt++;
                checks++;
                if (sat_words !== ((cnt > 7) ? 3'd7 : 3'(cnt))) begin
                    errors++; $display("FAIL sat_words got %0d exp %0d", sat_words, (cnt > 7) ? 7 : cnt);
                end
            end
        end
        sat_valid = 1'b0;
        checks++; if (cnt != 9) begin errors++; $display("FAIL sat_count got %0d exp 9", cnt); end
        checks++; if (sat_words !== 3'd7) begin errors++; $display("FAIL sat_final got %0d exp 7", sat_words); end
    endtask

    initial begin
        w_rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; wfull = 1'b0;
        sat_valid = 1'b0; sat_data = 8'h00; sat_last = 1'b0; sat_wfull = 1'b0;
        test_reset();
        test_stream();
        test_wfull_hold();
        test_wfull_toggle();
        test_pkt();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_stream.md
# fifo_wr_stream

Write-side producer for the asynchronous FIFO, in the w_clk domain: the client end of the FIFO write port (winc/wdata/wfull). Accepts words from an upstream valid/ready stream into a 2-entry skid buffer and drives winc/wdata only while the FIFO reports not-full, so no word is dropped or duplicated. Counts written words and, optionally, tracks packet boundaries.

## Interface
- DATA_WIDTH, 8, width of stream and FIFO data
- CNT_WIDTH, 16, width of word and packet counters

- w_clk  in  1  write-domain clock
- w_rst  in  1  asynchronous, active-low reset
- s_valid  in  1  upstream word valid
- s_data  in  DATA_WIDTH  upstream word
- s_last  in  1  last word of packet (used only with FIFO_WR_PKT_EN)
- s_ready  out  1  registered; block accepts word when s_valid && s_ready
- winc  out  1  FIFO write strobe, one word per cycle
- wdata  out  DATA_WIDTH  FIFO write data, valid when winc=1
- wfull  in  1  FIFO full flag from write-side controller
- wr_words  out  CNT_WIDTH  words written to FIFO, saturating
- pkt_cnt  out  CNT_WIDTH  packets completed, saturating (0 without macro)
- pkt_done  out  1  one-cycle pulse per completed packet (0 without macro)

## Operation
- Skid buffer: 2 entries, FIFO order, occupancy occ in {0,1,2}; each entry holds data + last bit.
- Push = s_valid && s_ready. Pop = winc. occ_next = occ + push - pop.
- winc = (occ != 0) && !wfull, combinational from registered occ and wfull input; wdata = head entry data.
- s_ready register: s_ready_next = (occ_next < 2). Guarantees occ never exceeds 2; s_valid while s_ready=0 is ignored and must be held by upstream.
- Simultaneous push and pop with occ=2 cannot occur (s_ready=0); with occ=1: head pops, new word becomes head next cycle, occ stays 1.
- wfull=1: winc forced 0, buffer holds, s_ready drops once occ reaches 2; resumes on first cycle wfull=0.
- wr_words increments on every winc; saturates at all-ones.
- Packet FSM (macro only): IDLE -> IN_PKT on push of a word with s_last=0; IN_PKT -> IDLE on pop of head with last=1. Push of single-word packet (s_last=1) in IDLE stays IDLE. pkt_done registered, asserted the cycle after the pop of a last word; pkt_cnt increments at that same edge, saturating.
- Reset values: s_ready=0, occ=0 (winc=0), wdata=0 buffer contents, wr_words=0, pkt_cnt=0, pkt_done=0, FSM=IDLE. s_ready goes 1 on first clock edge after reset release.
- Reset mid-operation: buffered words discarded, counters cleared; no winc during or in the first cycle after reset.

## Timing
- Latency: word pushed at edge N is presented with winc=1 in cycle N..N+1 (first cycle after the push edge) if wfull=0 and it is head.
- Throughput: 1 word/cycle sustained with s_valid=1, wfull=0.
- wfull lags the write that filled the FIFO by one cycle; block relies on the controller gating writes issued on that cycle and does not retry.
- s_ready reacts to a full buffer one cycle late by design; skid entry absorbs the word accepted in that cycle.

## Configuration
- FIFO_WR_PKT_EN defined: last bit stored per entry, packet FSM, pkt_cnt and pkt_done active.
- Undefined: s_last ignored, buffer stores data only, pkt_cnt tied 0, pkt_done tied 0; datapath and wr_words identical.

## Test plan
- Reset release, s_valid=1 with data 0x01..0x10 continuous, wfull=0 -> 16 consecutive winc cycles, wdata 0x01..0x10 in order, wr_words=16.
- Hold wfull=1 while driving 4 words -> s_ready=0 after 2 accepted, winc=0, occ=2; release wfull -> 2 buffered words then remaining 2 written, order preserved, none lost.
- Toggle wfull every cycle with continuous input 0xA0..0xA7 -> winc only when wfull=0, all 8 words written once in order.
- Assert w_rst low mid-stream with occ=2 -> winc=0, s_ready=0, wr_words=0 immediately; after release no stale word written.
- FIFO_WR_PKT_EN: send packets of 3 words and 1 word (s_last on 3rd and 1st) -> pkt_done pulses twice, each one cycle after last-word winc, pkt_cnt=2.
- Force wr_words to all-ones minus 1, write 3 words -> wr_words saturates at all-ones.
